// File: rtl/rf_arb_pkg.sv
// ============================================================================
//  Module   : rf_arb_pkg
//  Purpose  : Shared types and constants for the int_rf debug arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int         XLEN_DEF    = 32;
    localparam logic [4:0] RF_ZERO_IDX = 5'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        STALL  = 3'd2,
        ACCESS = 3'd3,
        RDATA  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // States during which the pipeline must be held frozen.
    function automatic logic in_stall_window(input state_t s);
        return (s == STALL) || (s == ACCESS) || (s == RDATA);
    endfunction

endpackage : rf_arb_pkg

`default_nettype wire

// File: rtl/rf_arb_starve_cnt.sv
// ============================================================================
//  Module   : rf_arb_starve_cnt
//  Purpose  : Saturating count of WB-busy cycles seen by a pending debug write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [4:0] HIT_AT = 5'(STARVE_LIMIT - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted when the increment about to happen reaches the limit.
    assign hit_o = ({1'b0, cnt_q} + 5'd1) >= HIT_AT;

endmodule : rf_arb_starve_cnt

`default_nettype wire

// File: rtl/rf_dbg_arbiter.sv
// ============================================================================
//  Module   : rf_dbg_arbiter
//  Purpose  : Shares int_rf between WB writeback and the debug unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_dbg_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_dst_i,
    input  logic [XLEN-1:0] wb_r_i,
    input  logic [4:0]      id_src1_i,
    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [4:0]      dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_ack_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    input  logic            pipe_stalled_i,
    output logic            stall_req_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic [4:0]      rf_src1_o,
    input  logic [XLEN-1:0] rf_src1_rdata_i
);

    state_t          state_q, state_d;
    logic            req_we_q, req_we_d;
    logic [4:0]      req_addr_q, req_addr_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            stall_req_q, stall_req_d;
    logic            cnt_clr, cnt_inc, cnt_hit;
    logic            dbg_wr_now, dbg_rd_now;

    rf_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .hit_o (cnt_hit)
    );

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        dbg_wr_now  = 1'b0;
        dbg_rd_now  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dbg_req_i) begin
                    req_we_d    = dbg_we_i;
                    req_addr_d  = dbg_addr_i;
                    req_wdata_d = dbg_wdata_i;
                    cnt_clr     = 1'b1;
                    state_d     = dbg_we_i ? ARB : STALL;
                end
            end
            ARB: begin
                if (!wb_we_i) begin
                    dbg_wr_now = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_hit) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (pipe_stalled_i) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A WB write that slips through still wins; retry next cycle.
                if (req_we_q) begin
                    if (!wb_we_i) begin
                        dbg_wr_now = 1'b1;
                        state_d    = DONE;
                    end
                end else begin
                    dbg_rd_now = 1'b1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                rdata_d = (req_addr_q == RF_ZERO_IDX) ? '0 : rf_src1_rdata_i;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered request: rises one cycle after STALL entry, low in DONE.
        stall_req_d = in_stall_window(state_q) && in_stall_window(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= RF_ZERO_IDX;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign rf_we_o     = dbg_wr_now ? (req_addr_q != RF_ZERO_IDX)
                                    : (wb_we_i && (wb_dst_i != RF_ZERO_IDX));
    assign rf_waddr_o  = dbg_wr_now ? req_addr_q  : wb_dst_i;
    assign rf_wdata_o  = dbg_wr_now ? req_wdata_q : wb_r_i;
    assign rf_src1_o   = dbg_rd_now ? req_addr_q  : id_src1_i;
    assign dbg_ack_o   = (state_q == DONE);
    assign dbg_rdata_o = rdata_q;
    assign stall_req_o = stall_req_q;

    a_no_wb_in_access : assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == ACCESS) && req_we_q) |-> !wb_we_i);

    a_stall_held : assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == ACCESS) || (state_q == RDATA)) |-> pipe_stalled_i);

endmodule : rf_dbg_arbiter

`default_nettype wire

// File: tb/tb_rf_dbg_arbiter.sv
// ============================================================================
//  Module   : tb_rf_dbg_arbiter
//  Purpose  : Self-checking bench for rf_dbg_arbiter with an int_rf model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_dbg_arbiter;

    localparam int          XLEN       = 32;
    localparam int          LIMIT      = 4;
    localparam logic [31:0] X0_GARBAGE = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_we_i;
    logic [4:0]      wb_dst_i;
    logic [XLEN-1:0] wb_r_i;
    logic [4:0]      id_src1_i;
    logic            dbg_req_i;
    logic            dbg_we_i;
    logic [4:0]      dbg_addr_i;
    logic [XLEN-1:0] dbg_wdata_i;
    logic            dbg_ack_o;
    logic [XLEN-1:0] dbg_rdata_o;
    logic            pipe_stalled_i;
    logic            stall_req_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic [4:0]      rf_src1_o;
    logic [XLEN-1:0] rf_src1_rdata_i;

    logic [31:0] regs [32] = '{default: 32'h0};
    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    // int_rf model: synchronous write, 1-cycle read; x0 reads return junk so
    // that the arbiter's own zeroing is observable.
    always @(posedge clk) begin
        if (rf_we_o) regs[rf_waddr_o] <= rf_wdata_o;
        rf_src1_rdata_i <= (rf_src1_o == 5'd0) ? X0_GARBAGE : regs[rf_src1_o];
    end

    rf_dbg_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_we_i         (wb_we_i),
        .wb_dst_i        (wb_dst_i),
        .wb_r_i          (wb_r_i),
        .id_src1_i       (id_src1_i),
        .dbg_req_i       (dbg_req_i),
        .dbg_we_i        (dbg_we_i),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_wdata_i     (dbg_wdata_i),
        .dbg_ack_o       (dbg_ack_o),
        .dbg_rdata_o     (dbg_rdata_o),
        .pipe_stalled_i  (pipe_stalled_i),
        .stall_req_o     (stall_req_o),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .rf_src1_o       (rf_src1_o),
        .rf_src1_rdata_i (rf_src1_rdata_i)
    );

    task automatic test_reset();
        rst_n = 1'b0; wb_we_i = 1'b1; wb_dst_i = 5'd9; wb_r_i = 32'h55;
        id_src1_i = 5'd12; dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 5'd0;
        dbg_wdata_i = '0; pipe_stalled_i = 1'b0;
        #1;
        checks++; if (dbg_ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", dbg_ack_o); else passed++;
        checks++; if (dbg_rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", dbg_rdata_o); else passed++;
        checks++; if (stall_req_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req_o); else passed++;
        checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h55})
            $display("FAIL reset_passthru_wr: got %b/%0d/%h want 1/9/55", rf_we_o, rf_waddr_o, rf_wdata_o); else passed++;
        checks++; if (rf_src1_o !== 5'd12) $display("FAIL reset_passthru_src1: got %0d want 12", rf_src1_o); else passed++;
        wb_dst_i = 5'd0;
        #1;
        checks++; if (rf_we_o !== 1'b0) $display("FAIL wb_x0_suppress: got %b want 0", rf_we_o); else passed++;
        wb_we_i = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write(input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        @(negedge clk);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = addr; dbg_wdata_i = data;
        sb.push_back('{1'b1, addr, (addr == 5'd0) ? 32'h0 : data});
        @(negedge clk);
        dbg_req_i = 1'b0;
        checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {(addr != 5'd0), addr, data})
            $display("FAIL wr_arb_drive: got %b/%0d/%h want %b/%0d/%h", rf_we_o, rf_waddr_o, rf_wdata_o, (addr != 5'd0), addr, data); else passed++;
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b00) $display("FAIL wr_arb_ack_stall: got %b want 00", {dbg_ack_o, stall_req_o}); else passed++;
        @(negedge clk);
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b10) $display("FAIL wr_done_ack_stall: got %b want 10", {dbg_ack_o, stall_req_o}); else passed++;
        e = sb.pop_front();
        checks++; if (regs[e.addr] !== e.data) $display("FAIL wr_rf_content: got %h want %h", regs[e.addr], e.data); else passed++;
        @(negedge clk);
        checks++; if (dbg_ack_o !== 1'b0) $display("FAIL wr_ack_one_cycle: got %b want 0", dbg_ack_o); else passed++;
    endtask

    task automatic test_starve_write(input logic [4:0] dst, input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        int   low = 0;
        bit   seen = 1'b0;
        @(negedge clk);
        wb_we_i = 1'b1; wb_dst_i = dst; wb_r_i = 32'h7000_0000;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = addr; dbg_wdata_i = data;
        sb.push_back('{1'b1, addr, data});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            dbg_req_i = 1'b0;
            if (stall_req_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                low++;
                checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {(dst != 5'd0), dst, wb_r_i})
                    $display("FAIL starve_wb_only: got %b/%0d/%h want %b/%0d/%h", rf_we_o, rf_waddr_o, rf_wdata_o, (dst != 5'd0), dst, wb_r_i); else passed++;
                wb_r_i = wb_r_i + 32'd1;
            end
        end
        checks++; if (seen !== 1'b1) $display("FAIL starve_stall_timeout: got %b want 1", seen); else passed++;
        // LIMIT-1 busy ARB cycles, then the STALL entry cycle before the request shows.
        checks++; if (low !== LIMIT) $display("FAIL starve_stall_delay: got %0d want %0d", low, LIMIT); else passed++;
        wb_we_i = 1'b0; pipe_stalled_i = 1'b1;
        @(negedge clk);
        checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, addr, data})
            $display("FAIL starve_access_wr: got %b/%0d/%h want 1/%0d/%h", rf_we_o, rf_waddr_o, rf_wdata_o, addr, data); else passed++;
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b01) $display("FAIL starve_access_ack_stall: got %b want 01", {dbg_ack_o, stall_req_o}); else passed++;
        @(negedge clk);
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b10) $display("FAIL starve_done_ack_stall: got %b want 10", {dbg_ack_o, stall_req_o}); else passed++;
        e = sb.pop_front();
        checks++; if (regs[e.addr] !== e.data) $display("FAIL starve_rf_content: got %h want %h", regs[e.addr], e.data); else passed++;
        @(negedge clk);
        pipe_stalled_i = 1'b0;
    endtask

    task automatic test_read(input logic [4:0] addr, input logic [31:0] val);
        exp_t e;
        int   low = 0;
        bit   seen = 1'b0;
        @(negedge clk);
        wb_we_i = 1'b1; wb_dst_i = addr; wb_r_i = val; id_src1_i = 5'd4;
        @(negedge clk);
        wb_we_i = 1'b0;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = addr;
        sb.push_back('{1'b0, addr, (addr == 5'd0) ? 32'h0 : val});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            dbg_req_i = 1'b0;
            if (stall_req_o === 1'b1) seen = 1'b1; else low++;
        end
        checks++; if ({seen, low[3:0]} !== {1'b1, 4'd1}) $display("FAIL rd_stall_rise: got seen=%b low=%0d want seen=1 low=1", seen, low); else passed++;
        pipe_stalled_i = 1'b1;
        @(negedge clk);
        checks++; if (rf_src1_o !== addr) $display("FAIL rd_access_src1: got %0d want %0d", rf_src1_o, addr); else passed++;
        checks++; if ({dbg_ack_o, stall_req_o, rf_we_o} !== 3'b010) $display("FAIL rd_access_ctl: got %b want 010", {dbg_ack_o, stall_req_o, rf_we_o}); else passed++;
        @(negedge clk);
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b01) $display("FAIL rd_rdata_ctl: got %b want 01", {dbg_ack_o, stall_req_o}); else passed++;
        @(negedge clk);
        checks++; if ({dbg_ack_o, stall_req_o} !== 2'b10) $display("FAIL rd_done_ack_stall: got %b want 10", {dbg_ack_o, stall_req_o}); else passed++;
        e = sb.pop_front();
        checks++; if (dbg_rdata_o !== e.data) $display("FAIL rd_data: got %h want %h", dbg_rdata_o, e.data); else passed++;
        @(negedge clk);
        pipe_stalled_i = 1'b0;
        checks++; if ({dbg_ack_o, dbg_rdata_o} !== {1'b0, e.data}) $display("FAIL rd_data_hold: got %b/%h want 0/%h", dbg_ack_o, dbg_rdata_o, e.data); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        bit seen = 1'b0;
        @(negedge clk);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd10; id_src1_i = 5'd4;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            dbg_req_i = 1'b0;
            if (stall_req_o === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) $display("FAIL rst_stall_timeout: got %b want 1", seen); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({stall_req_o, dbg_ack_o} !== 2'b00) $display("FAIL rst_async_clear: got %b want 00", {stall_req_o, dbg_ack_o}); else passed++;
        checks++; if (rf_src1_o !== 5'd4) $display("FAIL rst_src1_passthru: got %0d want 4", rf_src1_o); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({stall_req_o, dbg_ack_o} !== 2'b00) $display("FAIL rst_no_ack: got %b want 00", {stall_req_o, dbg_ack_o}); else passed++;
        end
        checks++; if (regs[10] !== 32'hA5A5_A5A5) $display("FAIL rst_rf_unchanged: got %h want a5a5a5a5", regs[10]); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd20; dbg_wdata_i = 32'h1;
        sb.push_back('{1'b1, 5'd20, 32'h1});
        @(negedge clk);
        checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd20}) $display("FAIL b2b_first_arb: got %b/%0d want 1/20", rf_we_o, rf_waddr_o); else passed++;
        dbg_addr_i = 5'd21; dbg_wdata_i = 32'h2;
        sb.push_back('{1'b1, 5'd21, 32'h2});
        @(negedge clk);
        checks++; if (dbg_ack_o !== 1'b1) $display("FAIL b2b_first_ack: got %b want 1", dbg_ack_o); else passed++;
        e = sb.pop_front();
        checks++; if (regs[e.addr] !== e.data) $display("FAIL b2b_first_rf: got %h want %h", regs[e.addr], e.data); else passed++;
        @(negedge clk);
        checks++; if ({rf_we_o, dbg_ack_o} !== 2'b00) $display("FAIL b2b_idle_gap: got %b want 00", {rf_we_o, dbg_ack_o}); else passed++;
        @(negedge clk);
        dbg_req_i = 1'b0;
        checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd21, 32'h2})
            $display("FAIL b2b_second_arb: got %b/%0d/%h want 1/21/2", rf_we_o, rf_waddr_o, rf_wdata_o); else passed++;
        @(negedge clk);
        checks++; if (dbg_ack_o !== 1'b1) $display("FAIL b2b_second_ack: got %b want 1", dbg_ack_o); else passed++;
        e = sb.pop_front();
        checks++; if (regs[e.addr] !== e.data) $display("FAIL b2b_second_rf: got %h want %h", regs[e.addr], e.data); else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write(5'd5, 32'hDEAD_BEEF);
        test_starve_write(5'd7, 5'd3, 32'h0000_1234);
        test_read(5'd10, 32'hA5A5_A5A5);
        test_write(5'd0, 32'hFFFF_FFFF);
        test_read(5'd0, 32'h1111_2222);
        test_reset_mid_stall();
        test_starve_write(5'd0, 5'd12, 32'h0000_0077);
        test_back_to_back();
        checks++; if (sb.size() !== 0) $display("FAIL sb_drained: got %0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule : tb_rf_dbg_arbiter

`default_nettype wire
